// File: rtl/i2c_byte_transmitter_if.sv
// Bus bundle for the I2C read-data transmitter: SCL edge strobes, SDA sense, byte
// handshake toward the target datapath, and the open-drain SDA pull-down.
interface i2c_byte_transmitter_if;
  logic       scl_rise;
  logic       scl_fall;
  logic       sda_in;
  logic       abort;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       sda_oe;
  logic       busy;
  logic       done;
  logic       acked;

  modport master (
    output scl_rise, scl_fall, sda_in, abort, tx_valid, tx_data,
    input  tx_ready, sda_oe, busy, done, acked
  );

  modport slave (
    input  scl_rise, scl_fall, sda_in, abort, tx_valid, tx_data,
    output tx_ready, sda_oe, busy, done, acked
  );
endinterface

// File: rtl/i2c_byte_transmitter.sv
// I2C target read-data serializer: shifts one byte MSB-first onto open-drain SDA
// on SCL falling edges, then samples the controller ACK/NACK on the 9th SCL rise.
module i2c_byte_transmitter (
  input  logic                    clk,
  input  logic                    reset,
  i2c_byte_transmitter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    ACK_WAIT = 2'd2,
    ACK_HOLD = 2'd3
  } state_e;

  state_e     state_q,   state_d;
  logic [7:0] shift_q,   shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       sda_oe_q,  sda_oe_d;
  logic       acked_q,   acked_d;
  logic       done_q,    done_d;

  // Simultaneous rise and fall is a protocol violation; treat it as no edge at all.
  logic rise_only;
  logic fall_only;
  assign rise_only = bus.scl_rise & ~bus.scl_fall;
  assign fall_only = bus.scl_fall & ~bus.scl_rise;

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      sda_oe_q  <= 1'b0;
      acked_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      sda_oe_q  <= sda_oe_d;
      acked_q   <= acked_d;
      done_q    <= done_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    sda_oe_d  = sda_oe_q;
    acked_d   = acked_q;
    done_d    = 1'b0;

    if (bus.abort) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          sda_oe_d = 1'b0;
          if (bus.tx_valid) begin
            shift_d   = bus.tx_data;
            bit_cnt_d = 3'd0;
            sda_oe_d  = ~bus.tx_data[7];
            state_d   = SEND;
          end
        end
        SEND: begin
          if (fall_only) begin
            if (bit_cnt_q != 3'd7) begin
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 3'd1;
              sda_oe_d  = ~shift_q[6];
            end else begin
              // Release SDA so the controller can drive the ACK slot.
              sda_oe_d = 1'b0;
              state_d  = ACK_WAIT;
            end
          end
        end
        ACK_WAIT: begin
          if (rise_only) begin
            acked_d = ~bus.sda_in;
            state_d = ACK_HOLD;
          end
        end
        ACK_HOLD: begin
          if (fall_only) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---- outputs ----
  always_comb begin
    bus.tx_ready = (state_q == IDLE);
    bus.busy     = (state_q != IDLE);
    bus.sda_oe   = sda_oe_q;
    bus.done     = done_q;
    bus.acked    = acked_q;
  end

endmodule

// File: tb/tb_i2c_byte_transmitter.sv
// Directed bench for i2c_byte_transmitter: ACK/NACK bytes, back-to-back transfer,
// abort, mid-byte reset, and coincident SCL edge strobes.
module tb_i2c_byte_transmitter;

  logic clk;
  logic reset;
  int   vecs;
  int   errs;

  i2c_byte_transmitter_if bus_if ();

  i2c_byte_transmitter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, vecs=%0d errs=%0d", vecs, errs);
    $fatal(1);
  end

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rise();
    bus_if.scl_rise = 1'b1;
    step();
    bus_if.scl_rise = 1'b0;
  endtask

  task automatic do_fall();
    bus_if.scl_fall = 1'b1;
    step();
    bus_if.scl_fall = 1'b0;
  endtask

  task automatic do_both();
    bus_if.scl_rise = 1'b1;
    bus_if.scl_fall = 1'b1;
    step();
    bus_if.scl_rise = 1'b0;
    bus_if.scl_fall = 1'b0;
  endtask

  task automatic offer(input logic [7:0] b);
    bus_if.tx_valid = 1'b1;
    bus_if.tx_data  = b;
    step();
    bus_if.tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    vecs++;
    if ({bus_if.tx_ready, bus_if.sda_oe, bus_if.busy, bus_if.done, bus_if.acked} !== 5'b10000) begin
      errs++;
      $display("FAIL reset_outputs: got rdy/oe/busy/done/ack=%b expected 10000",
               {bus_if.tx_ready, bus_if.sda_oe, bus_if.busy, bus_if.done, bus_if.acked});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_ack_a5();
    logic [7:0] exp;
    exp = 8'b0101_1010;
    offer(8'hA5);
    for (int i = 7; i >= 0; i--) begin
      vecs++;
      if (bus_if.sda_oe !== exp[i] || bus_if.busy !== 1'b1) begin
        errs++;
        $display("FAIL a5_bit%0d: oe=%b busy=%b expected oe=%b busy=1", i, bus_if.sda_oe, bus_if.busy, exp[i]);
      end
      do_rise();
      vecs++;
      if (bus_if.sda_oe !== exp[i]) begin
        errs++;
        $display("FAIL a5_high%0d: oe=%b expected %b", i, bus_if.sda_oe, exp[i]);
      end
      do_fall();
    end
    vecs++;
    if (bus_if.sda_oe !== 1'b0 || bus_if.done !== 1'b0) begin
      errs++;
      $display("FAIL a5_ack_release: oe=%b done=%b expected 0 0", bus_if.sda_oe, bus_if.done);
    end
    bus_if.sda_in = 1'b0;
    do_rise();
    bus_if.sda_in = 1'b1;
    vecs++;
    if (bus_if.acked !== 1'b1 || bus_if.done !== 1'b0 || bus_if.sda_oe !== 1'b0) begin
      errs++;
      $display("FAIL a5_ack_sample: acked=%b done=%b oe=%b expected 1 0 0", bus_if.acked, bus_if.done, bus_if.sda_oe);
    end
    do_fall();
    vecs++;
    if (bus_if.done !== 1'b1 || bus_if.acked !== 1'b1 || bus_if.tx_ready !== 1'b1) begin
      errs++;
      $display("FAIL a5_done: done=%b acked=%b rdy=%b expected 1 1 1", bus_if.done, bus_if.acked, bus_if.tx_ready);
    end
    step();
    vecs++;
    if (bus_if.done !== 1'b0 || bus_if.tx_ready !== 1'b1 || bus_if.acked !== 1'b1) begin
      errs++;
      $display("FAIL a5_after: done=%b rdy=%b acked=%b expected 0 1 1", bus_if.done, bus_if.tx_ready, bus_if.acked);
    end
  endtask

  task automatic test_nack_3c();
    logic [7:0] exp;
    exp = 8'b1100_0011;
    offer(8'h3C);
    for (int i = 7; i >= 0; i--) begin
      vecs++;
      if (bus_if.sda_oe !== exp[i]) begin
        errs++;
        $display("FAIL 3c_bit%0d: oe=%b expected %b", i, bus_if.sda_oe, exp[i]);
      end
      do_rise();
      do_fall();
    end
    bus_if.sda_in = 1'b1;
    do_rise();
    do_fall();
    vecs++;
    if (bus_if.done !== 1'b1 || bus_if.acked !== 1'b0) begin
      errs++;
      $display("FAIL 3c_nack_done: done=%b acked=%b expected 1 0", bus_if.done, bus_if.acked);
    end
    step();
  endtask

  task automatic test_back_to_back();
    offer(8'h00);
    for (int i = 7; i >= 0; i--) begin
      vecs++;
      if (bus_if.sda_oe !== 1'b1) begin
        errs++;
        $display("FAIL b2b_00_bit%0d: oe=%b expected 1", i, bus_if.sda_oe);
      end
      do_rise();
      do_fall();
    end
    bus_if.sda_in = 1'b0;
    do_rise();
    bus_if.sda_in = 1'b1;
    bus_if.tx_valid = 1'b1;
    bus_if.tx_data  = 8'hFF;
    do_fall();
    vecs++;
    if (bus_if.done !== 1'b1 || bus_if.acked !== 1'b1 || bus_if.tx_ready !== 1'b1) begin
      errs++;
      $display("FAIL b2b_done1: done=%b acked=%b rdy=%b expected 1 1 1", bus_if.done, bus_if.acked, bus_if.tx_ready);
    end
    step();
    bus_if.tx_valid = 1'b0;
    vecs++;
    if (bus_if.busy !== 1'b1 || bus_if.done !== 1'b0 || bus_if.sda_oe !== 1'b0) begin
      errs++;
      $display("FAIL b2b_accept2: busy=%b done=%b oe=%b expected 1 0 0", bus_if.busy, bus_if.done, bus_if.sda_oe);
    end
    for (int i = 7; i >= 0; i--) begin
      vecs++;
      if (bus_if.sda_oe !== 1'b0) begin
        errs++;
        $display("FAIL b2b_ff_bit%0d: oe=%b expected 0", i, bus_if.sda_oe);
      end
      do_rise();
      do_fall();
    end
    bus_if.sda_in = 1'b0;
    do_rise();
    bus_if.sda_in = 1'b1;
    do_fall();
    vecs++;
    if (bus_if.done !== 1'b1 || bus_if.acked !== 1'b1) begin
      errs++;
      $display("FAIL b2b_done2: done=%b acked=%b expected 1 1", bus_if.done, bus_if.acked);
    end
    step();
  endtask

  task automatic test_abort();
    logic [7:0] exp;
    exp = 8'b0111_1110;
    offer(8'h81);
    for (int i = 7; i >= 4; i--) begin
      vecs++;
      if (bus_if.sda_oe !== exp[i]) begin
        errs++;
        $display("FAIL abort_pre_bit%0d: oe=%b expected %b", i, bus_if.sda_oe, exp[i]);
      end
      do_rise();
      do_fall();
    end
    bus_if.abort = 1'b1;
    step();
    bus_if.abort = 1'b0;
    vecs++;
    if (bus_if.sda_oe !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.acked !== 1'b1) begin
      errs++;
      $display("FAIL abort_idle: oe=%b busy=%b done=%b acked=%b expected 0 0 0 1",
               bus_if.sda_oe, bus_if.busy, bus_if.done, bus_if.acked);
    end
    bus_if.abort = 1'b1;
    offer(8'h00);
    bus_if.abort = 1'b0;
    vecs++;
    if (bus_if.busy !== 1'b0 || bus_if.sda_oe !== 1'b0) begin
      errs++;
      $display("FAIL abort_vs_valid: busy=%b oe=%b expected 0 0", bus_if.busy, bus_if.sda_oe);
    end
    offer(8'h81);
    vecs++;
    if (bus_if.sda_oe !== 1'b0 || bus_if.busy !== 1'b1) begin
      errs++;
      $display("FAIL abort_restart: oe=%b busy=%b expected 0 1", bus_if.sda_oe, bus_if.busy);
    end
  endtask

  // Continues the 0x81 byte left in flight by test_abort.
  task automatic test_reset_mid_byte();
    offer(8'h55);
    vecs++;
    if (bus_if.sda_oe !== 1'b0 || bus_if.busy !== 1'b1) begin
      errs++;
      $display("FAIL busy_valid_ignored: oe=%b busy=%b expected 0 1", bus_if.sda_oe, bus_if.busy);
    end
    do_rise();
    do_fall();
    vecs++;
    if (bus_if.sda_oe !== 1'b1) begin
      errs++;
      $display("FAIL rst_fall1: oe=%b expected 1", bus_if.sda_oe);
    end
    do_rise();
    do_fall();
    vecs++;
    if (bus_if.sda_oe !== 1'b1) begin
      errs++;
      $display("FAIL rst_fall2: oe=%b expected 1", bus_if.sda_oe);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vecs++;
    if ({bus_if.tx_ready, bus_if.sda_oe, bus_if.busy, bus_if.done, bus_if.acked} !== 5'b10000) begin
      errs++;
      $display("FAIL rst_mid_byte: got rdy/oe/busy/done/ack=%b expected 10000",
               {bus_if.tx_ready, bus_if.sda_oe, bus_if.busy, bus_if.done, bus_if.acked});
    end
    for (int i = 0; i < 10; i++) begin
      do_rise();
      do_fall();
      vecs++;
      if (bus_if.sda_oe !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
        errs++;
        $display("FAIL rst_stay_idle%0d: oe=%b busy=%b done=%b expected 0 0 0",
                 i, bus_if.sda_oe, bus_if.busy, bus_if.done);
      end
    end
  endtask

  task automatic test_both_edges();
    logic [7:0] exp;
    exp = 8'b0110_1001;
    offer(8'h96);
    vecs++;
    if (bus_if.sda_oe !== exp[7]) begin
      errs++;
      $display("FAIL both_bit7: oe=%b expected %b", bus_if.sda_oe, exp[7]);
    end
    do_rise();
    do_fall();
    do_both();
    do_both();
    vecs++;
    if (bus_if.sda_oe !== exp[6] || bus_if.busy !== 1'b1) begin
      errs++;
      $display("FAIL both_hold: oe=%b busy=%b expected %b 1", bus_if.sda_oe, bus_if.busy, exp[6]);
    end
    for (int i = 6; i >= 0; i--) begin
      vecs++;
      if (bus_if.sda_oe !== exp[i]) begin
        errs++;
        $display("FAIL both_bit%0d: oe=%b expected %b", i, bus_if.sda_oe, exp[i]);
      end
      do_rise();
      do_fall();
    end
    bus_if.sda_in = 1'b0;
    do_both();
    vecs++;
    if (bus_if.acked !== 1'b0 || bus_if.busy !== 1'b1) begin
      errs++;
      $display("FAIL both_ackwait: acked=%b busy=%b expected 0 1", bus_if.acked, bus_if.busy);
    end
    do_rise();
    bus_if.sda_in = 1'b1;
    do_fall();
    vecs++;
    if (bus_if.done !== 1'b1 || bus_if.acked !== 1'b1 || bus_if.tx_ready !== 1'b1) begin
      errs++;
      $display("FAIL both_done: done=%b acked=%b rdy=%b expected 1 1 1", bus_if.done, bus_if.acked, bus_if.tx_ready);
    end
    step();
  endtask

  initial begin
    vecs            = 0;
    errs            = 0;
    reset           = 1'b1;
    bus_if.scl_rise = 1'b0;
    bus_if.scl_fall = 1'b0;
    bus_if.sda_in   = 1'b1;
    bus_if.abort    = 1'b0;
    bus_if.tx_valid = 1'b0;
    bus_if.tx_data  = 8'h00;

    test_reset();
    test_ack_a5();
    test_nack_3c();
    test_back_to_back();
    test_abort();
    test_reset_mid_byte();
    test_both_edges();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
